// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch front end: state encoding,
// default parameters and the {currentPC, nextPC, instr} beat type.
package if_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2,
    S_KILL  = 2'd3
  } fetch_state_e;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_PC_STEP  = 32'd4;
  localparam logic [31:0] NOP              = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] cur_pc;
    logic [31:0] next_pc;
    logic [31:0] instr;
  } fetch_beat_t;

  // Sequential PC advance; wraps modulo 2^32 with no alignment checking.
  function automatic logic [31:0] pc_advance(input logic [31:0] pc, input logic [31:0] step);
    return pc + step;
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry holding register for a fetched beat that could not be handed
// downstream because the output slot was still occupied.
module fetch_skid_buf
  import if_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        unload,
  input  logic        clear,
  input  fetch_beat_t din,
  output fetch_beat_t dout,
  output logic        full
);

  fetch_beat_t data_r;
  logic        full_r;

  // Storage: a squash (clear) wins over a new load, which wins over an unload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_r <= '{cur_pc: 32'h0, next_pc: 32'h0, instr: NOP};
      full_r <= 1'b0;
    end else if (clear) begin
      full_r <= 1'b0;
    end else if (load) begin
      data_r <= din;
      full_r <= 1'b1;
    end else if (unload) begin
      full_r <= 1'b0;
    end
  end

  assign dout = data_r;
  assign full = full_r;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: owns the PC, talks to instruction memory over
// req/rdy, absorbs downstream stall with a skid buffer and handles redirects.
module if_fetch_unit
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [31:0] PC_STEP  = DEFAULT_PC_STEP
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rdy,
  input  logic [31:0] imem_data,
  output logic [31:0] currentPC_out,
  output logic [31:0] nextPC_out,
  output logic [31:0] instrOut,
  output logic        valid_out
);

  fetch_state_e state_r;
  logic [31:0]  pc_r;
  logic [31:0]  kill_addr_r;
  fetch_beat_t  beat_r;
  logic         valid_r;

  logic         slot_free_s;
  logic         skid_load_s;
  logic         skid_unload_s;
  logic         skid_clear_s;
  logic         skid_full_s;
  fetch_beat_t  skid_beat_s;
  fetch_beat_t  fetch_beat_s;

  assign slot_free_s   = !valid_r || !stall;
  assign fetch_beat_s  = '{cur_pc: pc_r, next_pc: pc_advance(pc_r, PC_STEP), instr: imem_data};
  assign skid_clear_s  = redirect;
  assign skid_load_s   = !redirect && (state_r == S_FETCH) && imem_rdy && !slot_free_s;
  assign skid_unload_s = !redirect && (state_r == S_HOLD) && skid_full_s && !stall;

  fetch_skid_buf u_skid (
    .clk    (clk),
    .rst_n  (Reset),
    .load   (skid_load_s),
    .unload (skid_unload_s),
    .clear  (skid_clear_s),
    .din    (fetch_beat_s),
    .dout   (skid_beat_s),
    .full   (skid_full_s)
  );

  // Memory request decode; in S_KILL the address stays on the squashed request.
  always_comb begin
    imem_req  = 1'b0;
    imem_addr = 32'h0;
    case (state_r)
      S_FETCH: begin
        imem_req  = 1'b1;
        imem_addr = pc_r;
      end
      S_KILL: begin
        imem_req  = 1'b1;
        imem_addr = kill_addr_r;
      end
      default: begin
        imem_req  = 1'b0;
        imem_addr = 32'h0;
      end
    endcase
  end

  // Fetch sequencer: PC, state and the registered output triple.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state_r     <= S_IDLE;
      pc_r        <= RESET_PC;
      kill_addr_r <= 32'h0;
      beat_r      <= '{cur_pc: 32'h0, next_pc: 32'h0, instr: NOP};
      valid_r     <= 1'b0;
    end else if (redirect) begin
      pc_r    <= redirect_pc;
      valid_r <= 1'b0;
      case (state_r)
        S_FETCH: begin
          if (!imem_rdy) begin
            state_r     <= S_KILL;
            kill_addr_r <= pc_r;
          end else begin
            state_r <= S_FETCH;
          end
        end
        S_KILL:  state_r <= S_KILL;
        default: state_r <= S_FETCH;
      endcase
    end else begin
      case (state_r)
        S_IDLE: state_r <= S_FETCH;
        S_FETCH: begin
          if (imem_rdy) begin
            pc_r <= pc_advance(pc_r, PC_STEP);
            if (slot_free_s) begin
              beat_r  <= fetch_beat_s;
              valid_r <= 1'b1;
            end else begin
              state_r <= S_HOLD;
            end
          end else if (slot_free_s) begin
            valid_r <= 1'b0;
          end
        end
        S_HOLD: begin
          if (skid_unload_s) begin
            beat_r  <= skid_beat_s;
            valid_r <= 1'b1;
            state_r <= S_FETCH;
          end
        end
        S_KILL: begin
          // The response for the squashed address is dropped on arrival.
          if (imem_rdy) begin
            state_r <= S_FETCH;
          end
        end
        default: state_r <= S_IDLE;
      endcase
    end
  end

  assign currentPC_out = beat_r.cur_pc;
  assign nextPC_out    = beat_r.next_pc;
  assign instrOut      = beat_r.instr;
  assign valid_out     = valid_r;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench: the model is a plain sequential PC stream restarted on
// redirect/reset; a random-latency memory and random stall drive the DUT.
module tb_if_fetch_unit;
  import if_pkg::*;

  localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] STEP        = 32'd4;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] npc;
    logic [31:0] ins;
  } exp_t;

  logic        clk = 1'b0;
  logic        Reset, stall, redirect, imem_req, imem_rdy, valid_out;
  logic [31:0] redirect_pc, imem_addr, imem_data, currentPC_out, nextPC_out, instrOut;

  int          n_tests = 0;
  int          n_fail = 0;
  int          delivered = 0;
  int          lat_min = 0;
  int          lat_max = 0;
  exp_t        exp_q[$];
  logic [31:0] model_pc;

  if_fetch_unit #(.RESET_PC(TB_RESET_PC), .PC_STEP(STEP)) dut (
    .clk(clk), .Reset(Reset), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdy(imem_rdy), .imem_data(imem_data),
    .currentPC_out(currentPC_out), .nextPC_out(nextPC_out), .instrOut(instrOut),
    .valid_out(valid_out)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hA5A5_0F0F;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic feed();
    while (exp_q.size() < 8) begin
      exp_q.push_back('{pc: model_pc, npc: model_pc + STEP, ins: mem_word(model_pc)});
      model_pc = model_pc + STEP;
    end
  endtask

  task automatic cycle(input logic s, input logic r, input logic [31:0] t);
    @(posedge clk); #2;
    stall = s; redirect = r; redirect_pc = t;
    if (r) begin
      exp_q.delete();
      model_pc = t;
    end
    feed();
  endtask

  task automatic apply_reset();
    Reset = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    exp_q.delete();
    model_pc = TB_RESET_PC;
    feed();
  endtask

  // Runs unstalled cycles until a request is outstanding with no response yet.
  task automatic wait_pending(output logic found);
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      cycle(1'b0, 1'b0, 32'h0);
      if (imem_req && !imem_rdy) found = 1'b1;
    end
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 30 && !valid_out; i++) begin
      cycle(1'b0, 1'b0, 32'h0);
      @(negedge clk);
    end
  endtask

  // Memory model: random latency per request, data is a fixed function of address.
  initial begin : mem_model
    logic        busy;
    logic [31:0] held;
    int          wait_left;
    busy = 1'b0; held = 32'h0; wait_left = 0;
    imem_rdy = 1'b0; imem_data = 32'h0;
    forever begin
      @(posedge clk); #1;
      if (Reset && imem_req) begin
        if (busy) chk("addr_hold", imem_addr, held);
        else begin
          busy = 1'b1;
          held = imem_addr;
          wait_left = $urandom_range(lat_max, lat_min);
        end
        if (wait_left == 0) begin
          imem_rdy = 1'b1; imem_data = mem_word(imem_addr); busy = 1'b0;
        end else begin
          imem_rdy = 1'b0; imem_data = 32'hDEAD_BEEF; wait_left--;
        end
      end else begin
        imem_rdy = 1'b0; imem_data = 32'h0; busy = 1'b0;
      end
    end
  end

  // Monitor: pops the scoreboard on every consumed beat, checks hold and squash.
  initial begin : monitor
    logic        prev_hold, prev_redir;
    logic [31:0] prev_pc, prev_ins;
    exp_t        e;
    prev_hold = 1'b0; prev_redir = 1'b0; prev_pc = 32'h0; prev_ins = 32'h0;
    forever begin
      @(negedge clk);
      if (!Reset) begin
        prev_hold = 1'b0; prev_redir = 1'b0;
      end else begin
        if (prev_hold) begin
          chk("stall_hold_valid", {31'd0, valid_out}, 32'd1);
          chk("stall_hold_pc", currentPC_out, prev_pc);
          chk("stall_hold_instr", instrOut, prev_ins);
        end
        if (prev_redir) chk("redirect_squash", {31'd0, valid_out}, 32'd0);
        if (valid_out && !stall && !redirect) begin
          delivered++;
          if (exp_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL scoreboard_empty: got pc %h expected no beat", currentPC_out);
          end else begin
            e = exp_q.pop_front();
            chk("beat_pc", currentPC_out, e.pc);
            chk("beat_npc", nextPC_out, e.npc);
            chk("beat_instr", instrOut, e.ins);
          end
        end
        prev_hold = valid_out && stall && !redirect;
        prev_pc = currentPC_out; prev_ins = instrOut; prev_redir = redirect;
      end
    end
  end

  initial begin : stim
    logic found;
    apply_reset();
    repeat (3) @(posedge clk);
    #2;
    chk("rst_valid", {31'd0, valid_out}, 32'd0);
    chk("rst_cur", currentPC_out, 32'h0);
    chk("rst_next", nextPC_out, 32'h0);
    chk("rst_instr", instrOut, 32'h0);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    Reset = 1'b1;
    @(negedge clk); chk("idle_req", {31'd0, imem_req}, 32'd0);
    cycle(1'b0, 1'b0, 32'h0); @(negedge clk);
    chk("first_req", {31'd0, imem_req}, 32'd1);
    chk("first_addr", imem_addr, TB_RESET_PC);
    cycle(1'b0, 1'b0, 32'h0); @(negedge clk);
    chk("zw_cur0", currentPC_out, 32'h0);
    chk("zw_next0", nextPC_out, 32'h4);
    chk("zw_instr0", instrOut, mem_word(32'h0));
    cycle(1'b0, 1'b0, 32'h0); @(negedge clk); chk("zw_cur4", currentPC_out, 32'h4);
    cycle(1'b0, 1'b0, 32'h0); @(negedge clk); chk("zw_cur8", currentPC_out, 32'h8);

    // Stall with a response in flight parks it in the skid buffer.
    cycle(1'b1, 1'b0, 32'h0); @(negedge clk); chk("stall_cur", currentPC_out, 32'hC);
    cycle(1'b1, 1'b0, 32'h0); @(negedge clk);
    chk("hold_req", {31'd0, imem_req}, 32'd0);
    chk("hold_cur", currentPC_out, 32'hC);
    cycle(1'b0, 1'b0, 32'h0); @(negedge clk); chk("hold_frozen", currentPC_out, 32'hC);
    cycle(1'b0, 1'b0, 32'h0); @(negedge clk);
    chk("unload_cur", currentPC_out, 32'h10);
    chk("resume_addr", imem_addr, 32'h14);

    // Redirect while a request is outstanding.
    lat_min = 2; lat_max = 2;
    wait_pending(found);
    chk("kill_setup", {31'd0, found}, 32'd1);
    redirect = 1'b1; redirect_pc = 32'h400; exp_q.delete(); model_pc = 32'h400; feed();
    cycle(1'b0, 1'b0, 32'h0); @(negedge clk);
    chk("kill_req", {31'd0, imem_req}, 32'd1);
    wait_valid();
    chk("kill_first_pc", currentPC_out, 32'h400);

    // Redirect near the top of the address space: PC wraps to zero.
    lat_min = 0; lat_max = 0;
    cycle(1'b0, 1'b1, 32'hFFFF_FFF8); @(negedge clk);
    cycle(1'b0, 1'b0, 32'h0); @(negedge clk);
    wait_valid();
    chk("wrap_cur0", currentPC_out, 32'hFFFF_FFF8);
    cycle(1'b0, 1'b0, 32'h0); @(negedge clk);
    chk("wrap_cur1", currentPC_out, 32'hFFFF_FFFC);
    chk("wrap_next1", nextPC_out, 32'h0);
    cycle(1'b0, 1'b0, 32'h0); @(negedge clk);
    chk("wrap_cur2", currentPC_out, 32'h0);
    chk("wrap_next2", nextPC_out, 32'h4);

    // Redirect while parked in the skid buffer under stall.
    cycle(1'b1, 1'b0, 32'h0); @(negedge clk);
    cycle(1'b1, 1'b0, 32'h0); @(negedge clk);
    chk("skid_hold_req", {31'd0, imem_req}, 32'd0);
    cycle(1'b1, 1'b1, 32'h800); @(negedge clk);
    cycle(1'b1, 1'b0, 32'h0); @(negedge clk);
    chk("skid_squash", {31'd0, valid_out}, 32'd0);
    wait_valid();
    chk("skid_redirect_pc", currentPC_out, 32'h800);

    // Randomised traffic.
    lat_min = 0; lat_max = 3;
    for (int i = 0; i < 3000; i++) begin
      logic        r;
      logic [31:0] t;
      r = ($urandom_range(99, 0) < 5);
      t = ($urandom_range(9, 0) == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'h0000_FFFC);
      cycle(($urandom_range(99, 0) < 30), r, t);
    end
    chk("delivered_min", {31'd0, (delivered > 200)}, 32'd1);

    // Asynchronous reset in the middle of a request.
    lat_min = 3; lat_max = 3;
    wait_pending(found);
    chk("mid_rst_setup", {31'd0, found}, 32'd1);
    #1; Reset = 1'b0; #1;
    chk("mid_rst_valid", {31'd0, valid_out}, 32'd0);
    chk("mid_rst_cur", currentPC_out, 32'h0);
    chk("mid_rst_instr", instrOut, 32'h0);
    chk("mid_rst_req", {31'd0, imem_req}, 32'd0);
    chk("mid_rst_addr", imem_addr, 32'h0);
    apply_reset();
    repeat (2) @(posedge clk);
    #2; Reset = 1'b1;
    lat_min = 0; lat_max = 0;
    @(negedge clk);
    wait_valid();
    chk("post_rst_pc", currentPC_out, TB_RESET_PC);
    repeat (3) begin
      cycle(1'b0, 1'b0, 32'h0); @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
